lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 68 ++++++
 rtl/lsu_ctrl.sv | 139 +++++++++++++
 tb/tb_lsu_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Bus bundle for lsu_ctrl: AGU command, DTCM command/response and write-back.
// The slave modport is the LSU's view; master is the surrounding core/DTCM.
interface lsu_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int AW     = 16,
    parameter int ITAG_W = 2
);
    logic                agu_cmd_valid;
    logic                agu_cmd_ready;
    logic [AW-1:0]       agu_cmd_addr;
    logic                agu_cmd_read;
    logic [XLEN-1:0]     agu_cmd_wdata;
    logic [XLEN/8-1:0]   agu_cmd_wmask;
    logic [ITAG_W-1:0]   agu_cmd_itag;
    logic                agu_cmd_usign;
    logic [1:0]          agu_cmd_size;

    logic                dtcm_cmd_valid;
    logic                dtcm_cmd_ready;
    logic [AW-1:0]       dtcm_cmd_addr;
    logic                dtcm_cmd_read;
    logic [XLEN-1:0]     dtcm_cmd_wdata;
    logic [XLEN/8-1:0]   dtcm_cmd_wmask;

    logic                dtcm_rsp_valid;
    logic                dtcm_rsp_ready;
    logic [XLEN-1:0]     dtcm_rsp_rdata;
    logic                dtcm_rsp_err;

    logic                lsu_o_valid;
    logic                lsu_o_ready;
    logic [XLEN-1:0]     lsu_o_wbck_wdat;
    logic [ITAG_W-1:0]   lsu_o_wbck_itag;
    logic                lsu_o_wbck_err;
    logic                lsu_o_is_load;

    logic                lsu_active;

    modport slave (
        input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
               agu_cmd_wmask, agu_cmd_itag, agu_cmd_usign, agu_cmd_size,
        output agu_cmd_ready,
        output dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata,
               dtcm_cmd_wmask,
        input  dtcm_cmd_ready,
        input  dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err,
        output dtcm_rsp_ready,
        output lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
               lsu_o_is_load,
        input  lsu_o_ready,
        output lsu_active
    );

    modport master (
        output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
               agu_cmd_wmask, agu_cmd_itag, agu_cmd_usign, agu_cmd_size,
        input  agu_cmd_ready,
        input  dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata,
               dtcm_cmd_wmask,
        output dtcm_cmd_ready,
        output dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err,
        input  dtcm_rsp_ready,
        input  lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
               lsu_o_is_load,
        output lsu_o_ready,
        input  lsu_active
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit between the AGU and the DTCM: tracks up to two in-order
// outstanding accesses and formats load data into a one-deep write-back stage.
module lsu_ctrl #(
    parameter int XLEN   = 32,
    parameter int AW     = 16,
    parameter int ITAG_W = 2
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);

    typedef struct packed {
        logic              read;
        logic              usign;
        logic [1:0]        size;
        logic [1:0]        addr_lo;
        logic [ITAG_W-1:0] itag;
    } entry_t;

    logic [1:0]        count_q, count_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    entry_t            fifo_q [2];
    entry_t            head;
    entry_t            new_entry;
    logic              full, empty, push, pop;
    logic [AW-1:0]     cmd_addr;

    logic              wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]   wb_wdat_q, wb_wdat_d;
    logic [ITAG_W-1:0] wb_itag_q, wb_itag_d;
    logic              wb_err_q, wb_err_d;
    logic              wb_is_load_q, wb_is_load_d;
    logic [XLEN-1:0]   load_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);

    // Command path is pure pass-through, gated only by the outstanding queue.
    assign cmd_addr           = bus.agu_cmd_addr;
    assign bus.dtcm_cmd_valid = bus.agu_cmd_valid & ~full;
    assign bus.agu_cmd_ready  = bus.dtcm_cmd_ready & ~full;
    assign bus.dtcm_cmd_addr  = cmd_addr;
    assign bus.dtcm_cmd_read  = bus.agu_cmd_read;
    assign bus.dtcm_cmd_wdata = bus.agu_cmd_wdata;
    assign bus.dtcm_cmd_wmask = bus.agu_cmd_wmask;

    assign push = bus.dtcm_cmd_valid & bus.dtcm_cmd_ready;

    assign bus.dtcm_rsp_ready = ~empty & (~wb_valid_q | bus.lsu_o_ready);
    assign pop                = bus.dtcm_rsp_valid & bus.dtcm_rsp_ready;

    assign new_entry = '{read:    bus.agu_cmd_read,
                         usign:   bus.agu_cmd_usign,
                         size:    bus.agu_cmd_size,
                         addr_lo: cmd_addr[1:0],
                         itag:    bus.agu_cmd_itag};
    assign head = fifo_q[rd_ptr_q];

    always_comb begin
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: queue storage is not reset; count/pointers alone decide which slots are live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= new_entry;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        byte_sel  = 8'(bus.dtcm_rsp_rdata >> {head.addr_lo, 3'b000});
        half_sel  = 16'(bus.dtcm_rsp_rdata >> {head.addr_lo[1], 4'b0000});
        load_data = bus.dtcm_rsp_rdata;
        case (head.size)
            2'b00:   load_data = {{(XLEN-8){~head.usign & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{(XLEN-16){~head.usign & half_sel[15]}}, half_sel};
            default: load_data = bus.dtcm_rsp_rdata;
        endcase
        if (!head.read || bus.dtcm_rsp_err) load_data = '0;
    end

    // Payload only moves on a capture, so it holds while the consumer stalls.
    always_comb begin
        wb_valid_d   = wb_valid_q & ~bus.lsu_o_ready;
        wb_wdat_d    = wb_wdat_q;
        wb_itag_d    = wb_itag_q;
        wb_err_d     = wb_err_q;
        wb_is_load_d = wb_is_load_q;
        if (pop) begin
            wb_valid_d   = 1'b1;
            wb_wdat_d    = load_data;
            wb_itag_d    = head.itag;
            wb_err_d     = bus.dtcm_rsp_err;
            wb_is_load_d = head.read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_wdat_q    <= '0;
            wb_itag_q    <= '0;
            wb_err_q     <= 1'b0;
            wb_is_load_q <= 1'b0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            wb_wdat_q    <= wb_wdat_d;
            wb_itag_q    <= wb_itag_d;
            wb_err_q     <= wb_err_d;
            wb_is_load_q <= wb_is_load_d;
        end
    end

    assign bus.lsu_o_valid     = wb_valid_q;
    assign bus.lsu_o_wbck_wdat = wb_wdat_q;
    assign bus.lsu_o_wbck_itag = wb_itag_q;
    assign bus.lsu_o_wbck_err  = wb_err_q;
    assign bus.lsu_o_is_load   = wb_is_load_q;
    assign bus.lsu_active      = ~empty | wb_valid_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a negedge monitor tracks issued commands,
// predicts write-back results at each response handshake and scores them.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsu_ctrl_if #(.XLEN(32), .AW(16), .ITAG_W(2)) bus ();
    lsu_ctrl #(.XLEN(32), .AW(16), .ITAG_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic       read;
        logic       usign;
        logic [1:0] size;
        logic [1:0] lo;
        logic [1:0] itag;
    } cmd_t;

    typedef struct {
        logic [31:0] wdat;
        logic [1:0]  itag;
        logic        err;
        logic        is_load;
    } exp_t;

    cmd_t cmd_q[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   rsp_hs_prev = 0;

    function automatic exp_t model(cmd_t c, logic [31:0] rdata, logic err);
        exp_t e;
        logic [7:0]  b;
        logic [15:0] h;
        int          idx;
        idx       = 8 * int'(c.lo);
        b         = rdata[idx +: 8];
        h         = c.lo[1] ? rdata[31:16] : rdata[15:0];
        e.itag    = c.itag;
        e.err     = err;
        e.is_load = c.read;
        if (!c.read || err) e.wdat = 32'h0;
        else if (c.size == 2'b00) e.wdat = c.usign ? {24'h0, b} : {{24{b[7]}}, b};
        else if (c.size == 2'b01) e.wdat = c.usign ? {16'h0, h} : {{16{h[15]}}, h};
        else e.wdat = rdata;
        return e;
    endfunction

    // Scoreboard monitor: each negedge sees the handshakes about to fire on the next posedge.
    always @(negedge clk) begin
        cmd_t c;
        exp_t e;
        if (!rst_n) begin
            cmd_q.delete();
            exp_q.delete();
            rsp_hs_prev = 0;
        end else begin
            if (rsp_hs_prev) begin
                n_checks++;
                if (bus.lsu_o_valid !== 1'b1) $display("FAIL wb_latency: lsu_o_valid=%b want 1", bus.lsu_o_valid);
                else n_pass++;
            end
            if (bus.lsu_o_valid && bus.lsu_o_ready) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL wb_unexpected: itag=%0d with no prediction", bus.lsu_o_wbck_itag);
                else begin
                    e = exp_q.pop_front();
                    if (bus.lsu_o_wbck_wdat !== e.wdat || bus.lsu_o_wbck_itag !== e.itag ||
                        bus.lsu_o_wbck_err !== e.err || bus.lsu_o_is_load !== e.is_load)
                        $display("FAIL wb_payload: got wdat=%h itag=%0d err=%b ld=%b want wdat=%h itag=%0d err=%b ld=%b",
                                 bus.lsu_o_wbck_wdat, bus.lsu_o_wbck_itag, bus.lsu_o_wbck_err, bus.lsu_o_is_load,
                                 e.wdat, e.itag, e.err, e.is_load);
                    else n_pass++;
                end
            end
            rsp_hs_prev = bus.dtcm_rsp_valid && bus.dtcm_rsp_ready;
            if (rsp_hs_prev) begin
                n_checks++;
                if (cmd_q.size() == 0) $display("FAIL rsp_accepted_empty: response taken with nothing outstanding");
                else begin
                    n_pass++;
                    c = cmd_q.pop_front();
                    exp_q.push_back(model(c, bus.dtcm_rsp_rdata, bus.dtcm_rsp_err));
                end
            end
            if (bus.dtcm_cmd_valid && bus.dtcm_cmd_ready) begin
                n_checks++;
                if (bus.dtcm_cmd_addr !== bus.agu_cmd_addr || bus.dtcm_cmd_read !== bus.agu_cmd_read ||
                    bus.dtcm_cmd_wdata !== bus.agu_cmd_wdata || bus.dtcm_cmd_wmask !== bus.agu_cmd_wmask)
                    $display("FAIL cmd_passthru: got addr=%h rd=%b wd=%h wm=%h want addr=%h rd=%b wd=%h wm=%h",
                             bus.dtcm_cmd_addr, bus.dtcm_cmd_read, bus.dtcm_cmd_wdata, bus.dtcm_cmd_wmask,
                             bus.agu_cmd_addr, bus.agu_cmd_read, bus.agu_cmd_wdata, bus.agu_cmd_wmask);
                else n_pass++;
                c.read  = bus.agu_cmd_read;
                c.usign = bus.agu_cmd_usign;
                c.size  = bus.agu_cmd_size;
                c.lo    = bus.agu_cmd_addr[1:0];
                c.itag  = bus.agu_cmd_itag;
                cmd_q.push_back(c);
            end
        end
    end

    // Tasks below are entered and left at posedge+1.
    task automatic set_cmd(input logic rd, input logic us, input logic [1:0] sz,
                           input logic [15:0] addr, input logic [31:0] wd, input logic [1:0] tag);
        bus.agu_cmd_read  = rd;
        bus.agu_cmd_usign = us;
        bus.agu_cmd_size  = sz;
        bus.agu_cmd_addr  = addr;
        bus.agu_cmd_wdata = wd;
        bus.agu_cmd_wmask = rd ? 4'h0 : 4'hF;
        bus.agu_cmd_itag  = tag;
    endtask

    task automatic issue(input logic rd, input logic us, input logic [1:0] sz,
                         input logic [15:0] addr, input logic [31:0] wd, input logic [1:0] tag);
        bit done = 0;
        set_cmd(rd, us, sz, addr, wd, tag);
        bus.agu_cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.agu_cmd_ready;
            @(posedge clk); #1;
        end
        bus.agu_cmd_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL issue_timeout: agu_cmd_ready=0 want 1 within 50 cycles");
        end
    endtask

    task automatic respond(input logic [31:0] rdata, input logic err);
        bit done = 0;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = rdata;
        bus.dtcm_rsp_err   = err;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.dtcm_rsp_ready;
            @(posedge clk); #1;
        end
        bus.dtcm_rsp_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL respond_timeout: dtcm_rsp_ready=0 want 1 within 50 cycles");
        end
    endtask

    task automatic test_reset();
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_cmd_ready = 1'b0;
        #1;
        n_checks++;
        if (bus.lsu_o_valid !== 1'b0 || bus.lsu_active !== 1'b0 || bus.dtcm_rsp_ready !== 1'b0)
            $display("FAIL reset_outputs: valid=%b active=%b rsp_ready=%b want 0 0 0",
                     bus.lsu_o_valid, bus.lsu_active, bus.dtcm_rsp_ready);
        else n_pass++;
        n_checks++;
        if (bus.agu_cmd_ready !== 1'b0) $display("FAIL reset_agu_ready_lo: got %b want 0", bus.agu_cmd_ready);
        else n_pass++;
        bus.dtcm_cmd_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.agu_cmd_ready !== 1'b1) $display("FAIL reset_agu_ready_hi: got %b want 1", bus.agu_cmd_ready);
        else n_pass++;
        bus.dtcm_rsp_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic expect_wdat(input string name, input logic [31:0] want);
        @(negedge clk);
        n_checks++;
        if (bus.lsu_o_valid !== 1'b1 || bus.lsu_o_wbck_wdat !== want)
            $display("FAIL %s: valid=%b wdat=%h want valid=1 wdat=%h", name, bus.lsu_o_valid, bus.lsu_o_wbck_wdat, want);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        issue(1, 0, 2'b00, 16'h0003, 32'h0, 2'd0); respond(32'h80FF_1234, 0);
        expect_wdat("lb_signed", 32'hFFFF_FF80);
        issue(1, 1, 2'b01, 16'h0002, 32'h0, 2'd1); respond(32'h8001_7FFF, 0);
        expect_wdat("lhu", 32'h0000_8001);
        issue(1, 0, 2'b01, 16'h0002, 32'h0, 2'd2); respond(32'h8001_7FFF, 0);
        expect_wdat("lh_signed", 32'hFFFF_8001);
        issue(1, 1, 2'b00, 16'h0011, 32'h0, 2'd3); respond(32'h1234_F65A, 0);
        expect_wdat("lbu_addr1", 32'h0000_00F6);
        issue(1, 0, 2'b01, 16'h0100, 32'h0, 2'd0); respond(32'h0000_7FFF, 0);
        expect_wdat("lh_positive", 32'h0000_7FFF);
        issue(1, 0, 2'b10, 16'h0104, 32'h0, 2'd1); respond(32'hCAFE_BABE, 0);
        expect_wdat("lw", 32'hCAFE_BABE);
    endtask

    task automatic test_error();
        issue(1, 0, 2'b10, 16'h0008, 32'h0, 2'd2); respond(32'hDEAD_BEEF, 1);
        @(negedge clk);
        n_checks++;
        if (bus.lsu_o_wbck_err !== 1'b1 || bus.lsu_o_wbck_wdat !== 32'h0 || bus.lsu_o_wbck_itag !== 2'd2)
            $display("FAIL lw_error: err=%b wdat=%h itag=%0d want 1 00000000 2",
                     bus.lsu_o_wbck_err, bus.lsu_o_wbck_wdat, bus.lsu_o_wbck_itag);
        else n_pass++;
        @(posedge clk); #1;
        issue(0, 0, 2'b10, 16'h000C, 32'h5555_AAAA, 2'd3); respond(32'hFFFF_FFFF, 0);
        @(negedge clk);
        n_checks++;
        if (bus.lsu_o_is_load !== 1'b0 || bus.lsu_o_wbck_wdat !== 32'h0 || bus.lsu_o_wbck_err !== 1'b0)
            $display("FAIL store_wb: is_load=%b wdat=%h err=%b want 0 00000000 0",
                     bus.lsu_o_is_load, bus.lsu_o_wbck_wdat, bus.lsu_o_wbck_err);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        issue(0, 0, 2'b10, 16'h0020, 32'h1111_1111, 2'd0);
        issue(0, 0, 2'b10, 16'h0024, 32'h2222_2222, 2'd1);
        set_cmd(0, 0, 2'b10, 16'h0028, 32'h3333_3333, 2'd2);
        bus.agu_cmd_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.agu_cmd_ready !== 1'b0 || bus.dtcm_cmd_valid !== 1'b0 || bus.lsu_active !== 1'b1)
            $display("FAIL full_block: agu_ready=%b dtcm_valid=%b active=%b want 0 0 1",
                     bus.agu_cmd_ready, bus.dtcm_cmd_valid, bus.lsu_active);
        else n_pass++;
        @(posedge clk); #1;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h0;
        bus.dtcm_rsp_err   = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.dtcm_rsp_ready !== 1'b1 || bus.agu_cmd_ready !== 1'b0)
            $display("FAIL full_pop_cycle: rsp_ready=%b agu_ready=%b want 1 0", bus.dtcm_rsp_ready, bus.agu_cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.dtcm_rsp_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.agu_cmd_ready !== 1'b1) $display("FAIL full_release: agu_ready=%b want 1", bus.agu_cmd_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.agu_cmd_valid = 1'b0;
        respond(32'h0, 0);
        respond(32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.lsu_active !== 1'b0) $display("FAIL idle_active: lsu_active=%b want 0", bus.lsu_active);
        else n_pass++;
    endtask

    task automatic test_stall();
        bus.lsu_o_ready = 1'b0;
        issue(1, 0, 2'b10, 16'h0030, 32'h0, 2'd1);
        issue(1, 0, 2'b10, 16'h0034, 32'h0, 2'd2);
        respond(32'h1111_2222, 0);
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h3333_4444;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.dtcm_rsp_ready !== 1'b0 || bus.lsu_o_valid !== 1'b1 ||
                bus.lsu_o_wbck_wdat !== 32'h1111_2222 || bus.lsu_o_wbck_itag !== 2'd1)
                $display("FAIL stall_hold[%0d]: rsp_ready=%b valid=%b wdat=%h itag=%0d want 0 1 11112222 1",
                         i, bus.dtcm_rsp_ready, bus.lsu_o_valid, bus.lsu_o_wbck_wdat, bus.lsu_o_wbck_itag);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.lsu_o_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.dtcm_rsp_ready !== 1'b1) $display("FAIL stall_release: rsp_ready=%b want 1", bus.dtcm_rsp_ready);
        else n_pass++;
        @(posedge clk); #1;
        bus.dtcm_rsp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        fork
            for (int i = 0; i < 6; i++) issue(1, i[0], 2'(i % 3), 16'(16'h0040 + i), 32'h0, 2'(i));
            for (int i = 0; i < 6; i++) respond(32'h8000_0000 + 32'(i * 32'h0101_0181), 0);
            begin
                bit seen = 0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk);
                    seen = bus.lsu_o_valid;
                end
                n_checks++;
                if (!seen) $display("FAIL stream_start: lsu_o_valid=0 want 1 within 40 cycles");
                else n_pass++;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_checks++;
                    if (bus.lsu_o_valid !== 1'b1) $display("FAIL stream_rate[%0d]: lsu_o_valid=%b want 1", k, bus.lsu_o_valid);
                    else n_pass++;
                end
            end
        join
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        issue(1, 0, 2'b10, 16'h0050, 32'h0, 2'd0);
        issue(1, 0, 2'b10, 16'h0054, 32'h0, 2'd1);
        @(negedge clk);
        n_checks++;
        if (bus.lsu_active !== 1'b1) $display("FAIL midop_active: lsu_active=%b want 1", bus.lsu_active);
        else n_pass++;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.lsu_active !== 1'b0 || bus.lsu_o_valid !== 1'b0 || bus.dtcm_rsp_ready !== 1'b0)
            $display("FAIL midop_async: active=%b valid=%b rsp_ready=%b want 0 0 0",
                     bus.lsu_active, bus.lsu_o_valid, bus.dtcm_rsp_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.dtcm_rsp_valid = 1'b1;
        bus.dtcm_rsp_rdata = 32'h7777_7777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.dtcm_rsp_ready !== 1'b0 || bus.lsu_o_valid !== 1'b0)
                $display("FAIL post_reset_rsp[%0d]: rsp_ready=%b valid=%b want 0 0", i, bus.dtcm_rsp_ready, bus.lsu_o_valid);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus.dtcm_rsp_valid = 1'b0;
        issue(1, 1, 2'b00, 16'h0062, 32'h0, 2'd3); respond(32'h00AB_0000, 0);
        expect_wdat("post_reset_lbu", 32'h0000_00AB);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        bus.agu_cmd_valid  = 1'b0;
        set_cmd(0, 0, 2'b00, 16'h0, 32'h0, 2'd0);
        bus.dtcm_cmd_ready = 1'b1;
        bus.dtcm_rsp_valid = 1'b0;
        bus.dtcm_rsp_rdata = 32'h0;
        bus.dtcm_rsp_err   = 1'b0;
        bus.lsu_o_ready    = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_loads();
        test_error();
        test_full();
        test_stall();
        test_back_to_back();
        test_reset_midop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0 || cmd_q.size() != 0)
            $display("FAIL drain: %0d write-backs and %0d commands still pending, want 0 0", exp_q.size(), cmd_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
